// File: rtl/gs_latch_builder.sv
// rtl/gs_latch_builder.sv - double-buffered grayscale latch assembler feeding the LED shift-out stage
module gs_latch_builder #(
    parameter int LATCH_SIZE   = 769,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                  TESTCLK,
    input  logic                  nReset,
    input  logic [23:0]           pix_rgb,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    output logic [LATCH_SIZE-1:0] latch_data,
    output logic                  latch_valid,
    input  logic                  latch_ready,
    output logic                  sof_err,
    output logic [15:0]           latch_count
);

    localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int SEL_BIT = LATCH_SIZE - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    // Two latch buffers; one fills from the pixel side while the other is offered downstream
    logic [LATCH_SIZE-1:0] buf_mem [2];
    logic [1:0]            full;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [IDX_W-1:0]      pix_idx;

    logic                  pix_accept;
    logic                  latch_take;
    logic                  latch_done;
    logic                  sof_resync;
    logic [IDX_W-1:0]      ch_idx;
    logic [15:0]           r16;
    logic [15:0]           g16;
    logic [15:0]           b16;

    // Handshake outputs come straight from registered flags, so they are glitch-free
    assign pix_ready   = !full[wr_sel];
    assign latch_valid = full[rd_sel];
    assign latch_data  = buf_mem[rd_sel];

    assign pix_accept  = pix_valid && pix_ready;
    assign latch_take  = latch_valid && latch_ready;

    // A start-of-frame pixel always lands in channel 0, abandoning any partial latch
    assign ch_idx      = pix_sof ? '0 : pix_idx;
    assign sof_resync  = pix_accept && pix_sof && (pix_idx != '0);
    assign latch_done  = pix_accept && (ch_idx == LAST_IDX);

    // 8-bit to 16-bit expansion by replication maps 0x00->0x0000 and 0xFF->0xFFFF exactly
    assign r16 = {pix_rgb[23:16], pix_rgb[23:16]};
    assign g16 = {pix_rgb[15:8],  pix_rgb[15:8]};
    assign b16 = {pix_rgb[7:0],   pix_rgb[7:0]};

    // Write the expanded pixel into its channel slot of the filling buffer
    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (pix_accept) begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (ch_idx == IDX_W'(n)) begin
                    buf_mem[wr_sel][48*n      +: 16] <= r16;
                    buf_mem[wr_sel][48*n + 16 +: 16] <= g16;
                    buf_mem[wr_sel][48*n + 32 +: 16] <= b16;
                end
            end
            buf_mem[wr_sel][SEL_BIT] <= 1'b0;
        end
    end

    // Buffer ownership: completion marks the write side full, a take frees the read side
    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            full    <= 2'b00;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            pix_idx <= '0;
        end else begin
            if (latch_take) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
            if (latch_done) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (pix_accept) begin
                pix_idx <= latch_done ? '0 : ch_idx + 1'b1;
            end
        end
    end

    // Sticky resync flag, only reset clears it
    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            sof_err <= 1'b0;
        end else if (sof_resync) begin
            sof_err <= 1'b1;
        end
    end

    // Count latches handed downstream; natural 16-bit wrap
    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            latch_count <= '0;
        end else if (latch_take) begin
            latch_count <= latch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gs_latch_builder.sv
// tb/tb_gs_latch_builder.sv - scoreboard bench for gs_latch_builder
module tb_gs_latch_builder;

    logic         TESTCLK = 1'b0;
    logic         nReset;
    logic [23:0]  pix_rgb;
    logic         pix_valid;
    logic         pix_sof;
    logic         pix_ready;
    logic [768:0] latch_data;
    logic         latch_valid;
    logic         latch_ready;
    logic         sof_err;
    logic [15:0]  latch_count;

    int checks = 0;
    int errors = 0;
    int ready_drops = 0;
    bit stream_flag = 1'b0;

    logic [768:0] exp_q [$];
    logic [23:0]  lat_pix [16];
    logic [768:0] q_exp;

    gs_latch_builder #(.LATCH_SIZE(769), .NUM_CHANNELS(16)) dut (
        .TESTCLK    (TESTCLK),
        .nReset     (nReset),
        .pix_rgb    (pix_rgb),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .latch_data (latch_data),
        .latch_valid(latch_valid),
        .latch_ready(latch_ready),
        .sof_err    (sof_err),
        .latch_count(latch_count)
    );

    always #5 TESTCLK = !TESTCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [768:0] got, input logic [768:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [768:0] build_latch();
        logic [768:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[48*n      +: 16] = {lat_pix[n][23:16], lat_pix[n][23:16]};
            r[48*n + 16 +: 16] = {lat_pix[n][15:8],  lat_pix[n][15:8]};
            r[48*n + 32 +: 16] = {lat_pix[n][7:0],   lat_pix[n][7:0]};
        end
        return r;
    endfunction

    function automatic logic [23:0] gen_pix(input int l, input int n);
        logic [7:0] r, g, b;
        r = 8'((l * 37 + n * 11) & 255);
        g = 8'((l * 5 + n * 3 + 1) & 255);
        b = 8'((200 - n * 7 - l) & 255);
        return {r, g, b};
    endfunction

    // Present one pixel and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send_pix(input logic [23:0] v, input logic s);
        int n;
        n = 0;
        pix_rgb   = v;
        pix_sof   = s;
        pix_valid = 1'b1;
        @(negedge TESTCLK);
        while (!pix_ready && n < 64) begin
            n++;
            if (stream_flag) ready_drops++;
            @(negedge TESTCLK);
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_accept_timeout: pix_ready stayed 0 for %0d cycles", n);
        end
        @(posedge TESTCLK);
        #1;
    endtask

    task automatic idle(input int cycles);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (cycles) @(posedge TESTCLK);
        #1;
    endtask

    // Monitor: every take is compared against the oldest expected latch
    always @(negedge TESTCLK) begin
        if (nReset && latch_valid && latch_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL take_unexpected: latch taken with empty scoreboard, data %h", latch_data);
            end else begin
                chk("take_data", latch_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        nReset      = 1'b0;
        pix_rgb     = '0;
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        latch_ready = 1'b0;
        repeat (3) @(posedge TESTCLK);
        #1;
        nReset = 1'b1;

        chk("rst_latch_valid", 769'(latch_valid), 769'(0));
        chk("rst_pix_ready",   769'(pix_ready),   769'(1));
        chk("rst_sof_err",     769'(sof_err),     769'(0));
        chk("rst_latch_count", 769'(latch_count), 769'(0));
        chk("rst_latch_data",  latch_data,        769'(0));

        // green latch, latch_ready low
        for (int n = 0; n < 16; n++) begin
            lat_pix[n] = 24'h000A00;
            if (n == 15) chk("green_valid_before_last", 769'(latch_valid), 769'(0));
            send_pix(24'h000A00, n == 0);
        end
        exp_q.push_back(build_latch());
        chk("green_valid",  769'(latch_valid),       769'(1));
        chk("green_ready",  769'(pix_ready),         769'(1));
        chk("green_ch0_r",  769'(latch_data[15:0]),  769'(0));
        chk("green_ch0_g",  769'(latch_data[31:16]), 769'(16'h0A0A));
        chk("green_ch15_g", 769'(latch_data[767:752] & 16'h0) | 769'(latch_data[751:736]), 769'(16'h0A0A));
        chk("green_sel",    769'(latch_data[768]),   769'(0));

        // red latch fills the second buffer
        for (int n = 0; n < 16; n++) begin
            lat_pix[n] = 24'hFF0000;
            send_pix(24'hFF0000, 1'b0);
        end
        exp_q.push_back(build_latch());
        chk("both_full_ready", 769'(pix_ready),         769'(0));
        chk("both_full_data",  769'(latch_data[31:16]), 769'(16'h0A0A));

        // hold a pixel off while both buffers are full
        pix_rgb   = 24'h010203;
        pix_sof   = 1'b0;
        pix_valid = 1'b1;
        repeat (3) @(posedge TESTCLK);
        #1;
        chk("holdoff_ready", 769'(pix_ready),   769'(0));
        chk("holdoff_count", 769'(latch_count), 769'(0));

        // single take
        latch_ready = 1'b1;
        @(posedge TESTCLK);
        #1;
        latch_ready = 1'b0;
        chk("take1_count", 769'(latch_count),       769'(1));
        chk("take1_red",   769'(latch_data[15:0]),  769'(16'hFFFF));
        chk("take1_green", 769'(latch_data[31:16]), 769'(0));
        chk("take1_ready", 769'(pix_ready),         769'(1));

        // 5 pixels, then a mid-latch sof, then 15 more
        for (int n = 0; n < 5; n++) send_pix(24'h010203 + 24'(n), 1'b0);
        chk("sof_err_before", 769'(sof_err), 769'(0));
        lat_pix[0] = 24'h123456;
        send_pix(24'h123456, 1'b1);
        chk("sof_err_set", 769'(sof_err), 769'(1));
        for (int n = 1; n < 16; n++) begin
            lat_pix[n] = gen_pix(9, n);
            if (n == 15) chk("sof_latch_not_early", 769'(pix_ready), 769'(1));
            send_pix(lat_pix[n], 1'b0);
        end
        exp_q.push_back(build_latch());
        chk("sof_latch_full", 769'(pix_ready), 769'(0));

        // streaming with latch_ready held high
        latch_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int n = 0; n < 16; n++) begin
                lat_pix[n] = gen_pix(l, n);
                send_pix(lat_pix[n], n == 0);
                stream_flag = 1'b1;
            end
            exp_q.push_back(build_latch());
        end
        stream_flag = 1'b0;
        idle(2);
        chk("stream_ready_drops", 769'(ready_drops), 769'(0));
        chk("stream_count",       769'(latch_count), 769'(7));
        chk("stream_drained",     769'(latch_valid), 769'(0));

        // completion and take on the same edge
        latch_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            lat_pix[n] = gen_pix(20, n);
            send_pix(lat_pix[n], n == 0);
        end
        exp_q.push_back(build_latch());
        for (int n = 0; n < 16; n++) lat_pix[n] = gen_pix(21, n);
        q_exp = build_latch();
        for (int n = 0; n < 16; n++) begin
            if (n == 15) latch_ready = 1'b1;
            send_pix(lat_pix[n], n == 0);
        end
        latch_ready = 1'b0;
        chk("simul_count", 769'(latch_count), 769'(8));
        chk("simul_valid", 769'(latch_valid), 769'(1));
        chk("simul_ready", 769'(pix_ready),   769'(1));
        chk("simul_data",  latch_data,        q_exp);

        // reset mid-fill with one latch pending
        for (int n = 0; n < 7; n++) send_pix(gen_pix(30, n), n == 0);
        pix_valid = 1'b0;
        nReset    = 1'b0;
        @(posedge TESTCLK);
        #1;
        nReset = 1'b1;
        exp_q.delete();
        chk("rst2_latch_valid", 769'(latch_valid), 769'(0));
        chk("rst2_pix_ready",   769'(pix_ready),   769'(1));
        chk("rst2_latch_count", 769'(latch_count), 769'(0));
        chk("rst2_sof_err",     769'(sof_err),     769'(0));
        chk("rst2_latch_data",  latch_data,        769'(0));

        // fresh latch after reset
        for (int n = 0; n < 16; n++) begin
            lat_pix[n] = gen_pix(40, n);
            send_pix(lat_pix[n], n == 0);
        end
        exp_q.push_back(build_latch());
        pix_valid = 1'b0;
        chk("fresh_valid", 769'(latch_valid), 769'(1));
        latch_ready = 1'b1;
        @(posedge TESTCLK);
        #1;
        latch_ready = 1'b0;
        chk("fresh_count",    769'(latch_count), 769'(1));
        chk("fresh_drained",  769'(latch_valid), 769'(0));
        idle(2);
        chk("scoreboard_empty", 769'(exp_q.size()), 769'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
